// File: rtl/simon_key_schedule.sv
// Simon 128/128 on-the-fly round-key generator, one 64-bit key per transfer.
// Optional SIMON_KS_BACKPRESSURE_EN adds the kj_ready_i consumer handshake.
module simon_key_schedule #(
   parameter int NROUNDS = 68
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_i,
   input  logic         start_i,
   output logic [63:0]  kj_o,
   output logic         kj_valid_o,
`ifdef SIMON_KS_BACKPRESSURE_EN
   input  logic         kj_ready_i,
`endif
   output logic [6:0]   round_o,
   output logic         busy_o,
   output logic         done_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   // z2 with index 0 in the MSB position.
   localparam logic [61:0] Z2 =
      62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [63:0] C  = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam logic [6:0]  LAST = 7'(NROUNDS - 1);

   state_t      state_q, state_d;
   logic [63:0] ka_q, ka_d;
   logic [63:0] kb_q, kb_d;
   logic [6:0]  round_q, round_d;
   logic [5:0]  zidx_q, zidx_d;

   logic        ready;
   logic        run;
   logic        xfer;
   logic        zbit;
   logic [63:0] t;
   logic [63:0] knew;

`ifdef SIMON_KS_BACKPRESSURE_EN
   assign ready = kj_ready_i;
`else
   assign ready = 1'b1;
`endif

   assign run  = (state_q == S_RUN);
   assign xfer = run && ready;

   assign zbit = Z2[6'd61 - zidx_q];
   assign t    = {kb_q[2:0], kb_q[63:3]};
   assign knew = C ^ {63'b0, zbit} ^ ka_q ^ t ^ {t[0], t[63:1]};

   always_comb begin
      state_d = state_q;
      ka_d    = ka_q;
      kb_d    = kb_q;
      round_d = round_q;
      zidx_d  = zidx_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_RUN;
               ka_d    = key_i[63:0];
               kb_d    = key_i[127:64];
               round_d = '0;
               zidx_d  = '0;
            end
         end
         S_RUN: begin
            if (xfer) begin
               if (round_q == LAST) begin
                  state_d = S_DONE;
               end else begin
                  ka_d    = kb_q;
                  kb_d    = knew;
                  round_d = round_q + 7'd1;
                  zidx_d  = (zidx_q == 6'd61) ? 6'd0 : zidx_q + 6'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ka_q    <= '0;
         kb_q    <= '0;
         round_q <= '0;
         zidx_q  <= '0;
      end else begin
         state_q <= state_d;
         ka_q    <= ka_d;
         kb_q    <= kb_d;
         round_q <= round_d;
         zidx_q  <= zidx_d;
      end
   end

   // Outputs are masked outside RUN so IDLE/DONE always read as zero.
   assign kj_o       = run ? ka_q : '0;
   assign round_o    = run ? round_q : '0;
   assign kj_valid_o = run;
   assign busy_o     = run;
   assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_simon_key_schedule.sv
// Directed bench for simon_key_schedule with an independent Simon key model.
// Backpressure steps are built only when SIMON_KS_BACKPRESSURE_EN is defined.
module tb_simon_key_schedule;

   localparam int NR = 68;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] key_i;
   logic         start_i;
   logic [63:0]  kj_o;
   logic         kj_valid_o;
   logic [6:0]   round_o;
   logic         busy_o;
   logic         done_o;
   bit           rdy = 1'b1;

`ifdef SIMON_KS_BACKPRESSURE_EN
   logic         kj_ready_i;
   assign kj_ready_i = rdy;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [63:0] mk [0:NR-1];

   string Z2S =
      "10101111011100000011010010011000101000010001111110010110110011";

   always #5 clk = ~clk;

   simon_key_schedule #(.NROUNDS(NR)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_i      (key_i),
      .start_i    (start_i),
      .kj_o       (kj_o),
      .kj_valid_o (kj_valid_o),
`ifdef SIMON_KS_BACKPRESSURE_EN
      .kj_ready_i (kj_ready_i),
`endif
      .round_o    (round_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: k[i+2] = ~3 ^ z ^ k[i] ^ ROR(k[i+1],3) ^ ROR(k[i+1],4)
   function automatic void gen(input logic [127:0] key);
      logic [63:0] x;
      logic        zb;
      mk[0] = key[63:0];
      mk[1] = key[127:64];
      for (int i = 0; i < NR - 2; i++) begin
         x  = mk[i+1];
         zb = (Z2S[i % 62] == "1");
         mk[i+2] = ~64'd3 ^ {63'd0, zb} ^ mk[i]
                 ^ ((x >> 3) | (x << 61)) ^ ((x >> 4) | (x << 60));
      end
   endfunction

   task automatic idle_chk(input string tag);
      chk({tag, "_valid"}, {63'd0, kj_valid_o}, 64'd0);
      chk({tag, "_busy"},  {63'd0, busy_o},     64'd0);
      chk({tag, "_done"},  {63'd0, done_o},     64'd0);
      chk({tag, "_kj"},    kj_o,                64'd0);
      chk({tag, "_round"}, {57'd0, round_o},    64'd0);
   endtask

   // Full expansion; ign_rnd >= 0 pulses a foreign start at that round.
   task automatic run_check(input logic [127:0] key, input int ign_rnd,
                            input bit stall_en, input string tag);
      int i;
      int cyc;
      int st;
      int stalled_for;
      gen(key);
      key_i   = key;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      key_i   = ~key;
      i   = 0;
      cyc = 1;
      st  = 0;
      stalled_for = -1;
      while (i < NR && cyc < 400) begin
         if (i >= 62 && i <= 64)
            chk({tag, "_wrap_kj"}, kj_o, mk[i]);
         else
            chk({tag, "_kj"}, kj_o, mk[i]);
         chk({tag, "_round"}, {57'd0, round_o}, 64'(i));
         chk({tag, "_valid"}, {63'd0, kj_valid_o}, 64'd1);
         chk({tag, "_busy"},  {63'd0, busy_o},     64'd1);
         chk({tag, "_nodone"}, {63'd0, done_o},    64'd0);
         rdy = 1'b1;
         if (stall_en && (i == 0 || i == 30 || i == NR - 1)
             && stalled_for != i) begin
            if (st < 3) begin
               rdy = 1'b0;
               st++;
            end else begin
               stalled_for = i;
               st = 0;
            end
         end
         if (i == ign_rnd && rdy) begin
            start_i = 1'b1;
            key_i   = {64'hdead_beef_0bad_f00d, 64'h1234_5678_9abc_def0};
         end
         tick();
         start_i = 1'b0;
         if (rdy) i++;
         cyc++;
      end
      rdy = 1'b1;
      chk({tag, "_timeout"}, 64'(i), 64'(NR));
      chk({tag, "_latency"}, 64'(cyc), 64'(NR + 1 + (stall_en ? 9 : 0)));
      chk({tag, "_done"},    {63'd0, done_o},     64'd1);
      chk({tag, "_dvalid"},  {63'd0, kj_valid_o}, 64'd0);
      tick();
      idle_chk({tag, "_after"});
   endtask

   initial begin
      rst     = 1'b1;
      key_i   = '0;
      start_i = 1'b0;
      tick();
      tick();
      idle_chk("reset");
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         idle_chk("idle");
      end

      // Published Simon 128/128 key; first two keys are the halves.
      gen({64'h0f0e0d0c0b0a0908, 64'h0706050403020100});
      chk("vec_model_k0", mk[0], 64'h0706050403020100);
      key_i   = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("vec_k0", kj_o, 64'h0706050403020100);
      tick();
      chk("vec_k1", kj_o, 64'h0f0e0d0c0b0a0908);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      run_check({64'h0f0e0d0c0b0a0908, 64'h0706050403020100}, -1, 1'b0,
                "vec");

      // Zero key: k2 is just the round constant with z2[0] = 1.
      gen(128'd0);
      chk("zero_k2_hand", mk[2], 64'hFFFF_FFFF_FFFF_FFFD);
      run_check(128'd0, 10, 1'b0, "ignstart");

`ifdef SIMON_KS_BACKPRESSURE_EN
      run_check({64'h0f0e0d0c0b0a0908, 64'h0706050403020100}, -1, 1'b1,
                "stall");
`endif

      // Reset at round 40, then restart with a new key.
      key_i   = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210};
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 0; c < 40; c++) tick();
      chk("mid_round40", {57'd0, round_o}, 64'd40);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_chk("midrst");
      for (int c = 0; c < 30; c++) begin
         tick();
         chk("midrst_nodone", {63'd0, done_o}, 64'd0);
      end
      key_i   = {64'h5555_aaaa_3333_cccc, 64'h0f0f_f0f0_1111_eeee};
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("restart_k0",    kj_o, 64'h0f0f_f0f0_1111_eeee);
      chk("restart_round", {57'd0, round_o}, 64'd0);
      chk("restart_valid", {63'd0, kj_valid_o}, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/simon_key_schedule.md
# simon_key_schedule

Round-key generator for the Simon 128/128 datapath. It expands a 128-bit master key into the 68 64-bit round keys, one per transfer. It sits directly upstream of the Simon round stage and drives that stage's 64-bit round-key input each cycle. Keys are generated on the fly from two 64-bit state registers; no key RAM is used.

## Interface
- `NROUNDS`, default 68: number of round keys emitted per expansion; legal range 2..127.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_i`  in  128  master key, split as `{k1, k0}` with `k0 = key_i[63:0]`.
- `start_i`  in  1  starts an expansion; sampled only in IDLE.
- `kj_o`  out  64  current round key k[i].
- `kj_valid_o`  out  1  `kj_o` is valid.
- `kj_ready_i`  in  1  consumer accepts `kj_o`; present only under `SIMON_KS_BACKPRESSURE_EN`.
- `round_o`  out  7  index i of the key on `kj_o`.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  one-cycle pulse after the last key is accepted.

## Operation
- State registers: `ka` holds k[i], `kb` holds k[i+1], `round_q` holds i, `zidx_q` holds i mod 62.
- FSM states:
  - IDLE → RUN on `start_i`. On that edge: `ka <= key_i[63:0]`, `kb <= key_i[127:64]`, `round_q <= 0`, `zidx_q <= 0`.
  - RUN: `kj_o = ka`, `kj_valid_o = 1`. A transfer occurs when valid and ready are both high. On a transfer with i < NROUNDS-1: `ka <= kb`, `kb <= knew`, `round_q <= i+1`, `zidx_q <= (zidx_q == 61) ? 0 : zidx_q+1`.
  - RUN → DONE on the transfer with i == NROUNDS-1.
  - DONE: `done_o = 1` for one cycle, then → IDLE unconditionally. `start_i` is ignored in DONE.
- Next-key equation:
  - `t = ROR(kb,3)`
  - `knew = 64'hFFFF_FFFF_FFFF_FFFC ^ {63'b0, z2[zidx_q]} ^ ka ^ t ^ ROR(t,1)`
- z2 sequence, index 0 leftmost: 10101111011100000011010010011000101000010001111110010110110011. It is stored as a 62-bit constant.
- All arithmetic is bitwise, modulo 2^64. There are no adders.
- `start_i` asserted in RUN or DONE is ignored; it does not restart the expansion.
- `key_i` is sampled only on the start edge. Later changes to it have no effect on the running expansion.
- Reset mid-expansion: the next cycle is IDLE and all outputs are at their reset values. There is no partial key output and no `done_o`.
- Reset values: `kj_o=0`, `kj_valid_o=0`, `round_o=0`, `busy_o=0`, `done_o=0`. `ka`, `kb`, `round_q` and `zidx_q` are all 0.
- Outputs are registered or decoded directly from state. There is no combinational path from any input to any output.

## Timing
- `start_i` high in cycle T (IDLE): `kj_valid_o`/`busy_o` high from T+1, with `kj_o = k0` and `round_o = 0`.
- Without stalls, key i is presented in cycle T+1+i.
- The last key is presented at T+NROUNDS and `done_o` pulses at T+NROUNDS+1.
- IDLE is entered at T+NROUNDS+2; the earliest accepted restart is `start_i` in that cycle.
- Stall (`kj_ready_i=0`): `kj_o`, `round_o` and all state hold. `kj_valid_o` stays high.
- Wrap-around: key index 62 (generated when i = 60) uses z2[60]. Generating key 63 (i = 61) uses z2[61], after which `zidx_q` wraps to 0.

## Configuration
- `SIMON_KS_BACKPRESSURE_EN`
  - Defined: the `kj_ready_i` port exists and gates transfers as above.
  - Undefined: the port is absent and ready is internally tied high. One key is emitted per cycle in lockstep with the round stage.

## Test plan
- Reset then idle: hold `rst` 2 cycles, then leave `start_i` low for 10 cycles → all outputs 0, no `done_o`.
- Known vector: `key_i = 0x0f0e0d0c0b0a0908_0706050403020100`, pulse start at T. Required:
  - `kj_o` = 0x0706050403020100 at T+1 and 0x0f0e0d0c0b0a0908 at T+2.
  - k2..k67 match the golden software model bit for bit.
  - `done_o` pulses at T+69.
- z2 wrap: with `NROUNDS=68`, check that keys 62, 63 and 64 use z2[60], z2[61] and z2[0] respectively, against the model.
- Backpressure (macro defined): drop `kj_ready_i` at rounds 0, 30 and 67 for 3 cycles each → key and `round_o` hold; total latency grows by exactly 9 cycles; the sequence is unchanged.
- Ignored start: pulse `start_i` with a different `key_i` at round 10 → the sequence continues unchanged and `round_o` does not reset.
- Reset mid-run: assert `rst` at round 40 → the next cycle shows `kj_valid_o=0`, `busy_o=0` and no `done_o`. A new start then yields k0 of the new key one cycle later.
